// File: rtl/sda_kernel_control_pkg.sv
// Shared definitions for the sda_kernel_control slice: register offsets,
// CTRL bit positions, AXI response codes and the launch FSM state type.
package sda_kernel_control_pkg;

  // Byte offsets of the control registers
  localparam logic [31:0] ADDR_CTRL       = 32'h0000_0000;
  localparam logic [31:0] ADDR_GIE        = 32'h0000_0004;
  localparam logic [31:0] ADDR_IER        = 32'h0000_0008;
  localparam logic [31:0] ADDR_ISR        = 32'h0000_000C;
  localparam logic [31:0] ADDR_PARAM_BASE = 32'h0000_0010;

  // CTRL register bit positions
  localparam int CTRL_AP_START = 0;
  localparam int CTRL_AP_DONE  = 1;
  localparam int CTRL_AP_IDLE  = 2;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Kernel launch FSM
  typedef enum logic [1:0] {IDLE, GO, RUN} state_t;

  // True when a byte address falls on the given register word (bits [1:0] ignored)
  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] offset);
    return addr[31:2] == offset[31:2];
  endfunction

endpackage

// File: rtl/sda_axi_lite_slave.sv
// AXI-Lite slave handshake and response sequencing. Presents a single-cycle
// write strobe (wr_en) and read strobe (rd_en) to the register decode, which
// answers combinationally with wr_err and rd_data in the same cycle.
module sda_axi_lite_slave
  import sda_kernel_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  input  logic        wr_err,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        rd_ack
);

  logic        wr_accept_reg;
  logic        bvalid_reg;
  logic [1:0]  bresp_reg;
  logic        arready_reg;
  logic        rvalid_reg;
  logic [31:0] rdata_reg;

  // The address and data channels are accepted together; the master holds
  // both valid until the ready pulse, so the pulse cycle is the accept cycle.
  assign wr_en   = wr_accept_reg & s_axi_awvalid & s_axi_wvalid;
  assign wr_addr = s_axi_awaddr;
  assign wr_data = s_axi_wdata;
  assign wr_strb = s_axi_wstrb;

  assign rd_en   = arready_reg & s_axi_arvalid;
  assign rd_addr = s_axi_araddr;
  assign rd_ack  = rvalid_reg & s_axi_rready;

  assign s_axi_awready = wr_accept_reg;
  assign s_axi_wready  = wr_accept_reg;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = bresp_reg;
  assign s_axi_arready = arready_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = RESP_OKAY;

  // Write channel: one-cycle ready pulse, then hold the response until bready
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_accept_reg <= 1'b0;
      bvalid_reg    <= 1'b0;
      bresp_reg     <= RESP_OKAY;
    end else begin
      wr_accept_reg <= !wr_accept_reg && s_axi_awvalid && s_axi_wvalid && !bvalid_reg;
      if (wr_en) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_reg && s_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  // Read channel: one-cycle arready pulse, data registered and held until rready
  always_ff @(posedge clk) begin
    if (reset) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= 32'h0;
    end else begin
      arready_reg <= !arready_reg && s_axi_arvalid && !rvalid_reg;
      if (rd_en) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_data;
      end else if (rd_ack) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sda_kernel_control.sv
// Kernel control front end: AXI-Lite register map, go/done launch FSM and the
// parameter server feeding the action's paramaddr/paramdata channels.
// Optional interrupt logic (GIE/IER/ISR and the interrupt port) is built only
// when SDA_KERNEL_CONTROL_IRQ_EN is defined.
module sda_kernel_control
  import sda_kernel_control_pkg::*;
#(
  parameter int PARAM_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SDA_KERNEL_CONTROL_IRQ_EN
  output logic        interrupt,
`endif
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        go_0Ready,
  input  logic        go_0Stop,
  input  logic        done_0Ready,
  output logic        done_0Stop,
  input  logic        paramaddr_0Ready,
  input  logic [31:0] paramaddr_0Data,
  output logic        paramaddr_0Stop,
  output logic        paramdata_0Ready,
  output logic [31:0] paramdata_0Data,
  input  logic        paramdata_0Stop
);

  localparam int          IW      = $clog2(PARAM_WORDS);
  localparam logic [29:0] PB_WORD = ADDR_PARAM_BASE[31:2];

  logic        wr_en, rd_en, rd_ack, wr_err;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0]  wr_strb;

  state_t      state_reg, state_next;
  logic        ap_start_reg, ap_done_reg, rd_ctrl_reg;
  logic [31:0] param_reg [PARAM_WORDS];
  logic [PARAM_WORDS-1:0] param_we;
  logic        pd_ready_reg;
  logic [31:0] pd_data_reg;

  // Cache/prot carry no meaning for this register file
  logic unused_inputs;
  assign unused_inputs = &{1'b0, s_axi_awcache, s_axi_awprot, s_axi_arcache, s_axi_arprot,
                           wr_addr[1:0], rd_addr[1:0]};

  sda_axi_lite_slave u_axi (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack)
  );

  // ---------------- address decode ----------------
  logic [29:0]   wr_word, rd_word, wr_off, rd_off;
  logic          wr_param_hit, rd_param_hit;
  logic [IW-1:0] wr_pidx, rd_pidx;

  assign wr_word      = wr_addr[31:2];
  assign rd_word      = rd_addr[31:2];
  assign wr_off       = wr_word - PB_WORD;
  assign rd_off       = rd_word - PB_WORD;
  assign wr_param_hit = (wr_word >= PB_WORD) && (wr_off < 30'(PARAM_WORDS));
  assign rd_param_hit = (rd_word >= PB_WORD) && (rd_off < 30'(PARAM_WORDS));
  assign wr_pidx      = wr_off[IW-1:0];
  assign rd_pidx      = rd_off[IW-1:0];

  // Parameters are frozen while the action may be reading them
  assign wr_err = wr_en && wr_param_hit && (state_reg != IDLE);

  // ---------------- launch FSM ----------------
  logic start_wr, go_xfer, done_set;
  assign start_wr = wr_en && word_match(wr_addr, ADDR_CTRL) && wr_strb[0] && wr_data[CTRL_AP_START];
  assign go_xfer  = (state_reg == GO) && !go_0Stop;
  assign done_set = (state_reg == RUN) && done_0Ready;

  assign go_0Ready  = (state_reg == GO);
  assign done_0Stop = (state_reg != RUN);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state; a start write in IDLE launches on the same edge so go
  // appears in the cycle right after the CTRL accept
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ap_start_reg || start_wr) state_next = GO;
      GO:      if (go_xfer)                  state_next = RUN;
      RUN:     if (done_0Ready)              state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // CTRL status bits: start is W1S and cleared by the go transfer; done is
  // set on completion and cleared when a CTRL read response is taken (set wins)
  always_ff @(posedge clk) begin
    if (reset) begin
      ap_start_reg <= 1'b0;
      ap_done_reg  <= 1'b0;
      rd_ctrl_reg  <= 1'b0;
    end else begin
      if (start_wr)     ap_start_reg <= 1'b1;
      else if (go_xfer) ap_start_reg <= 1'b0;
      if (done_set)                   ap_done_reg <= 1'b1;
      else if (rd_ack && rd_ctrl_reg) ap_done_reg <= 1'b0;
      if (rd_en) rd_ctrl_reg <= word_match(rd_addr, ADDR_CTRL);
    end
  end

  // ---------------- parameter register file ----------------
  genvar gi;
  generate
    for (gi = 0; gi < PARAM_WORDS; gi++) begin : g_param_we
      assign param_we[gi] = wr_en && wr_param_hit && (state_reg == IDLE) && (wr_pidx == IW'(gi));
    end
  endgenerate

  // Byte-strobed parameter writes
  always_ff @(posedge clk) begin
    for (int w = 0; w < PARAM_WORDS; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (reset)                           param_reg[w][8*b +: 8] <= 8'h00;
        else if (param_we[w] && wr_strb[b])  param_reg[w][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------- parameter server ----------------
  assign paramaddr_0Stop  = pd_ready_reg;
  assign paramdata_0Ready = pd_ready_reg;
  assign paramdata_0Data  = pd_data_reg;

  // One outstanding index at a time; response held until it transfers
  always_ff @(posedge clk) begin
    if (reset) begin
      pd_ready_reg <= 1'b0;
      pd_data_reg  <= 32'h0;
    end else if (!pd_ready_reg) begin
      if (paramaddr_0Ready) begin
        pd_ready_reg <= 1'b1;
        pd_data_reg  <= (paramaddr_0Data < 32'(PARAM_WORDS)) ? param_reg[paramaddr_0Data[IW-1:0]] : 32'h0;
      end
    end else if (!paramdata_0Stop) begin
      pd_ready_reg <= 1'b0;
    end
  end

  // ---------------- optional interrupt ----------------
`ifdef SDA_KERNEL_CONTROL_IRQ_EN
  logic gie_reg, ier_reg, isr_reg, irq_reg;
  assign interrupt = irq_reg;

  // GIE/IER plain bit0, ISR toggled by write-1 and set by completion (set wins)
  always_ff @(posedge clk) begin
    if (reset) begin
      gie_reg <= 1'b0;
      ier_reg <= 1'b0;
      isr_reg <= 1'b0;
      irq_reg <= 1'b0;
    end else begin
      if (wr_en && word_match(wr_addr, ADDR_GIE) && wr_strb[0]) gie_reg <= wr_data[0];
      if (wr_en && word_match(wr_addr, ADDR_IER) && wr_strb[0]) ier_reg <= wr_data[0];
      if (done_set) isr_reg <= 1'b1;
      else if (wr_en && word_match(wr_addr, ADDR_ISR) && wr_strb[0] && wr_data[0]) isr_reg <= !isr_reg;
      irq_reg <= gie_reg & ier_reg & isr_reg;
    end
  end
`endif

  // Read mux, captured by the slave on the arready handshake
  always_comb begin
    rd_data = 32'h0;
    if (word_match(rd_addr, ADDR_CTRL)) begin
      rd_data[CTRL_AP_START] = ap_start_reg;
      rd_data[CTRL_AP_DONE]  = ap_done_reg;
      rd_data[CTRL_AP_IDLE]  = (state_reg == IDLE);
    end else if (rd_param_hit) begin
      rd_data = param_reg[rd_pidx];
    end
`ifdef SDA_KERNEL_CONTROL_IRQ_EN
    else if (word_match(rd_addr, ADDR_GIE)) rd_data[0] = gie_reg;
    else if (word_match(rd_addr, ADDR_IER)) rd_data[0] = ier_reg;
    else if (word_match(rd_addr, ADDR_ISR)) rd_data[0] = isr_reg;
`endif
  end

endmodule

// File: doc/sda_kernel_control.md
# sda_kernel_control

Host-facing control and parameter front end for a single kernel action. It terminates the 32-bit AXI-Lite slave bus and decodes a control and parameter register map. It launches the action through the go/done SELF channel pair and serves the action's paramaddr/paramdata read requests from the parameter register file. It sits directly upstream of the kernel action top-level and connects to it port for port.

## Interface
- PARAM_WORDS, 16: number of 32-bit parameter registers (2..64).
- clk  in  1  sole clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- s_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  —  32/4/2  AXI-Lite write channels. Cache/prot inputs are accepted and ignored.
- s_axi_araddr/arvalid/arready, rdata/rresp/rvalid/rready  —  32/2  AXI-Lite read channels.
- go_0Ready  out  1 / go_0Stop  in  1  action start token.
- done_0Ready  in  1 / done_0Stop  out  1  action completion token.
- paramaddr_0Ready  in  1, paramaddr_0Data  in  32, paramaddr_0Stop  out  1  parameter word-index request.
- paramdata_0Ready  out  1, paramdata_0Data  out  32, paramdata_0Stop  in  1  parameter value response.
- interrupt  out  1  level interrupt. Present only with the IRQ macro.

## Operation
- SELF channel transfer: a transfer occurs on a cycle where Ready=1 and Stop=0. The sender holds Data stable while Ready=1.
- Register map (byte address, bits [1:0] ignored):
  - 0x00 CTRL: bit0 ap_start (W1S, RO readback), bit1 ap_done (RO, clear-on-read), bit2 ap_idle (RO).
  - 0x04 GIE.
  - 0x08 IER bit0.
  - 0x0C ISR bit0 (write-1-toggle).
  - 0x10+4*i PARAM[i], for i < PARAM_WORDS.
- wstrb honoured per byte on PARAM/GIE/IER. CTRL/ISR act on byte 0 only.
- Unmapped read returns 0, OKAY. Unmapped write is dropped, OKAY.
- PARAM write while the FSM is not IDLE is dropped with bresp=SLVERR (2'b10).
- FSM:
  - IDLE: ap_idle=1. Moves to GO when ap_start=1.
  - GO: go_0Ready=1. On transfer, clears ap_start and moves to RUN.
  - RUN: done_0Stop=0. On done_0Ready=1, moves to IDLE, sets ap_done and sets ISR.
  - done_0Stop=1 in IDLE and GO.
- Param server: paramaddr_0Stop=0 only when no response is pending. An accepted index i drives paramdata_0Data=PARAM[i], or 0 if i ≥ PARAM_WORDS. paramdata_0Ready=1 until the response transfers. The server is usable in every FSM state.
- Simultaneous ap_done set (RUN exit) and clear (CTRL read handshake): set wins.
- Reset, including mid-run: FSM returns to IDLE. All registers, including PARAM, clear to 0. Any in-flight AXI or param transaction is abandoned.

## Timing
- Reset values: arready, awready, wready, rvalid, bvalid, go_0Ready, paramdata_0Ready, interrupt = 0. done_0Stop = 1. paramaddr_0Stop = 0. rdata, rresp, bresp, paramdata_0Data = 0.
- Write path:
  - awready and wready are asserted together for one cycle, the cycle after both awvalid and wvalid are seen.
  - The register update takes effect on that accept edge.
  - bvalid rises the next cycle and holds until bready.
  - No new write is accepted while bvalid=1.
- Read path:
  - arready pulses one cycle after arvalid.
  - rvalid and rdata follow one cycle later and hold until rready.
  - The clear-on-read of ap_done happens on the rvalid&rready cycle.
- Start latency: CTRL write accepted at edge T → go_0Ready=1 in cycle T+1.
- Param latency: index accepted at edge N → paramdata_0Ready=1 in cycle N+1. The next index can be accepted in the cycle after the response transfers.
- Read and write channels are independent and may complete in the same cycle.

## Configuration
- SDA_KERNEL_CONTROL_IRQ_EN defined:
  - GIE/IER/ISR are implemented.
  - interrupt = GIE[0] & IER[0] & ISR[0], registered.
- Undefined:
  - The interrupt port is absent.
  - 0x04–0x0C read 0 and writes are dropped with OKAY.
  - The ISR logic is not built.

## Structure
- Shared package holds:
  - register offset constants (CTRL, GIE, IER, ISR, PARAM_BASE);
  - CTRL bit positions;
  - AXI response codes OKAY=2'b00, SLVERR=2'b10;
  - FSM state enum {IDLE, GO, RUN}.
- One sub-module, sda_axi_lite_slave: AXI-Lite handshake and response sequencing. It exposes a single-cycle wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data interface to the register decode in the top.

## Test plan
- Write PARAM[3]=0xDEADBEEF, then paramaddr index 3 → paramdata_0Data=0xDEADBEEF one cycle after accept. Index 20 (PARAM_WORDS=16) → data 0.
- Write CTRL=0x1 with go_0Stop=1 for 5 cycles → go_0Ready held for those cycles. go_0Stop drops → RUN, ap_start reads 0. done_0Ready pulse → CTRL reads 0x6, second read 0x4.
- Write PARAM[0] during RUN → bresp=SLVERR, PARAM[0] unchanged. Read 0x100 → rdata 0, OKAY.
- Completion on the same cycle as the CTRL-read handshake → the next CTRL read shows ap_done=1.
- Reset asserted in RUN → go_0Ready=0, done_0Stop=1, CTRL reads 0x4, PARAM[3] reads 0.
- IRQ_EN: GIE=1, IER=1, run to completion → interrupt=1. Write ISR=1 → interrupt=0 one cycle after accept.
